// File: rtl/cardinal_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cardinal_fetch_unit
//  Description : Instruction-fetch front end. Issues requests on an imem
//                request/grant port, collects in-order responses into a
//                prefetch buffer and hands them to decode via valid/ready.
//                A redirect flushes the buffer and discards the responses
//                that are still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module cardinal_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    PC_STEP    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [INST_WIDTH-1:0]         imem_rdata,
    input  logic                          redirect,
    input  logic [ADDR_WIDTH-1:0]         redirect_addr,
    output logic                          inst_valid,
    output logic [INST_WIDTH-1:0]         inst_out,
    output logic [ADDR_WIDTH-1:0]         inst_pc,
    input  logic                          inst_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          protocol_err
);

    localparam int                    c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int                    c_cnt_w = c_ptr_w + 1;
    localparam logic [ADDR_WIDTH-1:0] c_step  = ADDR_WIDTH'(PC_STEP);
    localparam logic [c_cnt_w:0]      c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    r_outstanding;
    logic [c_cnt_w-1:0]    r_drop_cnt;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic                  r_protocol_err;
    logic [INST_WIDTH-1:0] r_mem_inst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];

    logic w_credit;
    logic w_req;
    logic w_hs;
    logic w_resp;
    logic w_stray;
    logic w_drop;
    logic w_push;
    logic w_pop;
    logic w_valid;

    // Credit counts both buffered and in-flight entries, so every granted
    // request is guaranteed a buffer slot when its response returns.
    assign w_credit = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_depth;
    assign w_req    = !reset && !redirect && w_credit;
    assign w_hs     = w_req && imem_gnt;
    assign w_resp   = imem_rvalid && (r_outstanding != '0);
    assign w_stray  = imem_rvalid && (r_outstanding == '0);
    assign w_drop   = w_resp && (r_drop_cnt != '0);
    assign w_push   = w_resp && !w_drop && !redirect;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && inst_ready && !redirect;

    assign imem_req     = w_req;
    assign imem_addr    = r_fetch_pc;
    assign inst_valid   = w_valid;
    assign inst_out     = w_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign inst_pc      = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign fifo_count   = r_count;
    assign protocol_err = r_protocol_err;

    // Buffer storage: written only on an accepted, non-stale response.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    // Fetch/response bookkeeping; redirect overrides push, pop and request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc     <= RESET_PC;
            r_resp_pc      <= RESET_PC;
            r_count        <= '0;
            r_outstanding  <= '0;
            r_drop_cnt     <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            // In-flight responses keep returning after a redirect, so the
            // outstanding count is maintained regardless of redirect.
            r_outstanding <= r_outstanding + c_cnt_w'(w_hs) - c_cnt_w'(w_resp);

            if (w_stray) begin
                r_protocol_err <= 1'b1;
            end

            if (redirect) begin
                r_fetch_pc <= redirect_addr;
                r_resp_pc  <= redirect_addr;
                r_count    <= '0;
                r_rd_ptr   <= r_wr_ptr;
                // Everything still in flight after this cycle is stale.
                r_drop_cnt <= r_outstanding - c_cnt_w'(w_resp);
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + c_step;
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + c_ptr_w'(1);
                    r_resp_pc <= r_resp_pc + c_step;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
                end
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cardinal_fetch_unit
//  Description : Self-checking bench for cardinal_fetch_unit: a directed
//                vector table, hand-written corner sequences and a random
//                phase checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        protocol_err;

    always #5 clk = ~clk;

    cardinal_fetch_unit #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .FIFO_DEPTH (4),
        .PC_STEP    (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .fifo_count    (fifo_count),
        .protocol_err  (protocol_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffer as queues, one stale flag per in-flight request.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_resp_pc;
    logic [31:0] m_buf_inst [$];
    logic [31:0] m_buf_pc   [$];
    bit          m_stale    [$];
    bit          m_perr;

    // Behavioural imem: in-order responses with a per-request latency.
    logic [31:0] resp_data_q [$];
    int          resp_due_q  [$];
    int          last_due;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          dut_hs  = 0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_fetch_pc = 32'h0;
        m_resp_pc  = 32'h0;
        m_buf_inst.delete();
        m_buf_pc.delete();
        m_stale.delete();
        m_perr = 1'b0;
        resp_data_q.delete();
        resp_due_q.delete();
        last_due = cyc;
    endtask

    // Asynchronous reset: outputs are checked before any clock edge occurs.
    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_addr = '0;
        inst_ready  = 1'b0;
        #1;
        chk("rst_imem_req",   32'(imem_req),     32'h0);
        chk("rst_imem_addr",  imem_addr,         32'h0);
        chk("rst_inst_valid", 32'(inst_valid),   32'h0);
        chk("rst_inst_out",   inst_out,          32'h0);
        chk("rst_inst_pc",    inst_pc,           32'h0);
        chk("rst_fifo_count", 32'(fifo_count),   32'h0);
        chk("rst_protocol_err", 32'(protocol_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, compare DUT against model, advance model.
    task automatic cycle(input bit gnt, input bit redir, input logic [31:0] raddr,
                         input bit rdy, input bit spurious);
        bit          rv;
        logic [31:0] rd;
        bit          exp_req;
        bit          exp_valid;
        bit          hs;
        bit          st;
        int          lat;
        int          due;
        @(negedge clk);
        rv = 1'b0;
        rd = '0;
        if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
            rv = 1'b1;
            rd = resp_data_q.pop_front();
            void'(resp_due_q.pop_front());
        end else if (spurious && m_stale.size() == 0) begin
            rv = 1'b1;
            rd = 32'hBAD0_BAD0;
        end
        imem_gnt      = gnt;
        imem_rvalid   = rv;
        imem_rdata    = rd;
        redirect      = redir;
        redirect_addr = raddr;
        inst_ready    = rdy;
        #1;
        exp_req   = !redir && (m_buf_pc.size() + m_stale.size() < 4);
        exp_valid = (m_buf_pc.size() != 0);
        chk("imem_req",   32'(imem_req),   32'(exp_req));
        chk("imem_addr",  imem_addr,       m_fetch_pc);
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_out", inst_out, m_buf_inst[0]);
            chk("inst_pc",  inst_pc,  m_buf_pc[0]);
        end
        chk("fifo_count",   32'(fifo_count),   32'(m_buf_pc.size()));
        chk("protocol_err", 32'(protocol_err), 32'(m_perr));
        if (imem_req && gnt) dut_hs++;

        hs = exp_req && gnt;
        if (exp_valid && rdy && !redir) begin
            void'(m_buf_inst.pop_front());
            void'(m_buf_pc.pop_front());
        end
        if (rv) begin
            if (m_stale.size() > 0) begin
                st = m_stale.pop_front();
                if (!st && !redir) begin
                    m_buf_inst.push_back(rd);
                    m_buf_pc.push_back(m_resp_pc);
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end else begin
                m_perr = 1'b1;
            end
        end
        if (hs) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            resp_data_q.push_back(imem_word(m_fetch_pc));
            resp_due_q.push_back(due);
            m_stale.push_back(1'b0);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            m_buf_inst.delete();
            m_buf_pc.delete();
            foreach (m_stale[i]) m_stale[i] = 1'b1;
            m_fetch_pc = raddr;
            m_resp_pc  = raddr;
        end
        cyc++;
    endtask

    // Runs until the first valid head appears and checks its PC.
    task automatic expect_first_pc(input string name, input logic [31:0] pc);
        bit          got;
        logic [31:0] first_pc;
        got      = 1'b0;
        first_pc = '0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            if (inst_valid) begin
                got      = 1'b1;
                first_pc = inst_pc;
            end
        end
        chk({name, "_seen"}, 32'(got), 32'h1);
        chk(name, first_pc, pc);
    endtask

    typedef struct {
        bit          gnt;
        bit          rvalid;
        logic [31:0] rdata;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        int          e_count;
    } vec_t;

    vec_t vt [8];

    initial begin
        // Streaming fetch, grant every cycle, response one cycle after grant.
        vt[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h0,         32'h00, 0};
        vt[1] = '{1'b1, 1'b1, 32'h1000_0000, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0,         32'h00, 0};
        vt[2] = '{1'b1, 1'b1, 32'h1000_0004, 1'b1, 1'b1, 32'h08, 1'b1, 32'h1000_0000, 32'h00, 1};
        vt[3] = '{1'b1, 1'b1, 32'h1000_0008, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h1000_0004, 32'h04, 1};
        vt[4] = '{1'b1, 1'b1, 32'h1000_000C, 1'b1, 1'b1, 32'h10, 1'b1, 32'h1000_0008, 32'h08, 1};
        vt[5] = '{1'b0, 1'b1, 32'h1000_0010, 1'b1, 1'b1, 32'h14, 1'b1, 32'h1000_000C, 32'h0C, 1};
        vt[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14, 1'b1, 32'h1000_0010, 32'h10, 1};
        vt[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14, 1'b0, 32'h0,         32'h00, 0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            imem_gnt    = vt[i].gnt;
            imem_rvalid = vt[i].rvalid;
            imem_rdata  = vt[i].rdata;
            inst_ready  = vt[i].ready;
            redirect    = 1'b0;
            #1;
            chk($sformatf("vec%0d_req", i),   32'(imem_req),   32'(vt[i].e_req));
            chk($sformatf("vec%0d_addr", i),  imem_addr,       vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_inst", i), inst_out, vt[i].e_inst);
                chk($sformatf("vec%0d_pc", i),   inst_pc,  vt[i].e_pc);
            end
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].e_count));
        end

        // Stalled decode: credit limits the handshakes to the buffer depth.
        do_reset();
        lat_min = 1; lat_max = 1; dut_hs = 0;
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_hs",    32'(dut_hs),     32'd4);
        chk("stall_req",   32'(imem_req),   32'h0);
        chk("stall_count", 32'(fifo_count), 32'd4);
        chk("stall_pc",    inst_pc,         32'h0);
        chk("stall_inst",  inst_out,        imem_word(32'h0));
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("resume_hs", 32'(dut_hs > 4), 32'h1);

        // Redirect with three requests in flight.
        do_reset();
        lat_min = 4; lat_max = 4;
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("redir_valid", 32'(inst_valid), 32'h0);
        chk("redir_addr",  imem_addr,       32'h100);
        expect_first_pc("redir_first_pc", 32'h100);

        // Redirect coinciding with a response and a pop, occupancy two.
        do_reset();
        lat_min = 2; lat_max = 2;
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        chk("rvredir_count_before", 32'(fifo_count), 32'd2);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("rvredir_valid", 32'(inst_valid), 32'h0);
        chk("rvredir_count", 32'(fifo_count), 32'h0);
        chk("rvredir_addr",  imem_addr,       32'h200);
        expect_first_pc("rvredir_first_pc", 32'h200);

        // Fetch address wraps at the top of the address space.
        do_reset();
        lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_addr_zero", imem_addr, 32'h0);
        expect_first_pc("wrap_first_pc", 32'hFFFF_FFFC);

        // Stray response sets a sticky error; reset clears it.
        do_reset();
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("perr_set",   32'(protocol_err), 32'h1);
        chk("perr_count", 32'(fifo_count),   32'h0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("perr_sticky", 32'(protocol_err), 32'h1);

        // Random traffic against the model, with periodic mid-run resets.
        lat_min = 1; lat_max = 4;
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int n = 0; n < 1000; n++) begin
                bit          g;
                bit          r;
                bit          d;
                bit          s;
                logic [31:0] a;
                g = ($urandom_range(99) < 70);
                r = ($urandom_range(99) < 70);
                d = ($urandom_range(99) < 4);
                s = ($urandom_range(199) == 0);
                a = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
                cycle(g, d, a, r, s);
            end
        end
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cardinal_fetch_unit.md
Name: cardinal_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation cardinal processor core. It replaces the single-cycle PC/IF_ID scheme with a request/grant imem interface, variable imem latency, and a FIFO_DEPTH-entry prefetch buffer. Decode consumes instructions through a valid/ready handshake, so an ID-stage stall is simply inst_ready low. A branch redirect from ID flushes the buffer and discards stale in-flight responses.

Parameters:
ADDR_WIDTH, 32, width of PC and imem address
INST_WIDTH, 32, instruction width
FIFO_DEPTH, 4, prefetch buffer entries; power of 2, >=2
PC_STEP, 4, PC increment per fetched instruction
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_WIDTH  fetch address; equals fetch_pc
imem_gnt  in  1  imem accepts the request this cycle
imem_rvalid  in  1  response data valid; responses return in request order
imem_rdata  in  INST_WIDTH  response instruction
redirect  in  1  branch taken in ID; one-cycle pulse
redirect_addr  in  ADDR_WIDTH  branch target
inst_valid  out  1  head of buffer valid
inst_out  out  INST_WIDTH  head instruction
inst_pc  out  ADDR_WIDTH  PC of head instruction
inst_ready  in  1  decode accepts the head this cycle (low = stall)
fifo_count  out  clog2(FIFO_DEPTH)+1  current buffer occupancy
protocol_err  out  1  sticky: imem_rvalid received with nothing in flight

Behaviour:
- Reset (asynchronous, active-high): fetch_pc=RESET_PC; resp_pc=RESET_PC; occupancy, outstanding and drop_cnt=0; imem_req=0; inst_valid=0; inst_out=0; inst_pc=0; fifo_count=0; protocol_err=0.
- Reset asserted mid-transfer clears all state. Responses arriving after reset deasserts with outstanding=0 set protocol_err and are discarded.
- Request: imem_req = !redirect && (occupancy + outstanding < FIFO_DEPTH). This credit rule guarantees the buffer never overflows.
- Request handshake = imem_req && imem_gnt. On a handshake: fetch_pc += PC_STEP (wraps modulo 2^ADDR_WIDTH) and outstanding++.
- imem_addr is held stable while imem_req=1 and imem_gnt=0.
- Response: each imem_rvalid with outstanding>0 decrements outstanding.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise, if redirect=0: push {imem_rdata, resp_pc} and set resp_pc += PC_STEP.
- Pop: inst_valid && inst_ready && !redirect removes the head.
- Latency: rvalid in cycle t makes the entry visible on inst_valid at t+1. There is no bypass. Push and pop in the same cycle leave occupancy unchanged.
- inst_valid = (occupancy != 0). inst_out and inst_pc show the head entry and are held stable while inst_valid=1 and inst_ready=0.
- Redirect has priority over push, pop and request in the same cycle:
  - occupancy <= 0, and inst_valid=0 in the next cycle.
  - fetch_pc <= redirect_addr; resp_pc <= redirect_addr.
  - drop_cnt <= outstanding - (imem_rvalid ? 1 : 0). All remaining in-flight responses are stale.
  - An rvalid arriving in the redirect cycle is discarded.
  - imem_req=0 in the redirect cycle. The first request to the new target is issued the following cycle.
- Back-to-back redirects: the second one overrides the first. drop_cnt is recomputed from the current outstanding.
- fifo_count = occupancy, registered.
- Counter widths are clog2(FIFO_DEPTH)+1; no counter ever exceeds FIFO_DEPTH.

Test Plan:
- Reset, imem_gnt=1, rvalid 1 cycle after each grant, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8,... in order; first inst_valid 2 cycles after the first grant.
- inst_ready=0, FIFO_DEPTH=4, zero-latency grants -> exactly 4 handshakes, then imem_req=0; fifo_count=4; inst_out holds the PC 0 instruction. Raise inst_ready -> one pop per cycle and requests resume.
- 3 requests in flight (rvalid latency 3), then redirect to 0x100 -> next cycle inst_valid=0 and imem_addr=0x100; the 3 stale responses are discarded; the first delivered inst_pc=0x100.
- Redirect in the same cycle as rvalid and pop with occupancy=2 -> buffer empty, the rvalid is dropped, drop_cnt = outstanding-1.
- fetch_pc=0xFFFFFFFC with ADDR_WIDTH=32 -> next request address 0x00000000.
- rvalid pulsed with outstanding=0 -> protocol_err=1 and stays set; fifo_count unchanged. Assert reset -> protocol_err=0.
